// File: rtl/serial_add32_pkg.sv
// Shared definitions for the byte-serial adder: FSM state encoding and slice width.
`timescale 1ns/1ps
package serial_add32_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow of the top byte: carry into the MSB differs from carry out of it.
  function automatic logic msb_overflow(
    input logic a_msb,
    input logic b_msb,
    input logic sum_msb,
    input logic carry_out
  );
    return carry_out ^ (a_msb ^ b_msb ^ sum_msb);
  endfunction

endpackage

// File: rtl/serial_add32_add8_slice.sv
// Combinational 8-bit ripple-carry adder slice shared by every byte of the serial add.
`timescale 1ns/1ps
module add8_slice
  import serial_add32_pkg::*;
(
  input  logic [BYTE_W-1:0] A,
  input  logic [BYTE_W-1:0] B,
  input  logic              Cin,
  output logic [BYTE_W-1:0] S,
  output logic              Cout
);

  logic [BYTE_W:0] w_c;

  assign w_c[0] = Cin;

  genvar gi;
  generate
    for (gi = 0; gi < BYTE_W; gi++) begin : g_bit
      assign S[gi]      = A[gi] ^ B[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign Cout = w_c[BYTE_W];

endmodule

// File: rtl/serial_add32.sv
// Byte-serial wide adder: one add8_slice reused LSB-first, start/done handshake around it.
`timescale 1ns/1ps
module serial_add32
  import serial_add32_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BYTE_W*WORDS-1:0] A,
  input  logic [BYTE_W*WORDS-1:0] B,
  input  logic                    Cin,
  output logic [BYTE_W*WORDS-1:0] S,
  output logic                    Cout,
  output logic                    ovf,
  output logic                    busy,
  output logic                    done
);

  localparam int N     = BYTE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             r_state;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic               r_cout;
  logic               r_ovf;
  logic [BYTE_W-1:0]  r_s [WORDS];

  logic [BYTE_W-1:0]  w_a_bytes [WORDS];
  logic [BYTE_W-1:0]  w_b_bytes [WORDS];
  logic [BYTE_W-1:0]  w_slice_a;
  logic [BYTE_W-1:0]  w_slice_b;
  logic [BYTE_W-1:0]  w_slice_sum;
  logic               w_slice_cout;
  logic               w_accept;
  logic               w_running;
  logic               w_last;

  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_running = (r_state == RUN);
  assign w_last    = w_running && (r_idx == LAST_IDX);

  assign w_slice_a = w_a_bytes[r_idx];
  assign w_slice_b = w_b_bytes[r_idx];

  add8_slice u_slice (
    .A    (w_slice_a),
    .B    (w_slice_b),
    .Cin  (r_carry),
    .S    (w_slice_sum),
    .Cout (w_slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout  <= w_slice_cout;
            r_ovf   <= msb_overflow(r_a[N-1], r_b[N-1], w_slice_sum[BYTE_W-1], w_slice_cout);
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Each result byte owns its register; it is cleared on accept and written on its RUN cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_byte
      assign w_a_bytes[gi] = r_a[gi*BYTE_W +: BYTE_W];
      assign w_b_bytes[gi] = r_b[gi*BYTE_W +: BYTE_W];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s[gi] <= '0;
        end else if (w_accept) begin
          r_s[gi] <= '0;
        end else if (w_running && (r_idx == IDX_W'(gi))) begin
          r_s[gi] <= w_slice_sum;
        end
      end

      assign S[gi*BYTE_W +: BYTE_W] = r_s[gi];
    end
  endgenerate

  assign Cout = r_cout;
  assign ovf  = r_ovf;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_serial_add32.sv
// Self-checking bench for serial_add32: directed table, multi-cycle corner sequences, random vs. arithmetic model.
`timescale 1ns/1ps
module tb_serial_add32;

  localparam int WORDS = 4;
  localparam int N     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] S;
  logic         Cout;
  logic         ovf;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  serial_add32 #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .S     (S),
    .Cout  (Cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic void ref_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                                  output logic [N-1:0] s, output logic co, output logic ov);
    logic [N:0] tot;
    tot = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    s   = tot[N-1:0];
    co  = tot[N];
    ov  = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  // Accept one operation, scramble inputs afterwards, wait (bounded) for done.
  // lat = number of rising edges after the accept edge at which done is first seen.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                        output logic [N-1:0] o_s, output logic o_cout, output logic o_ovf,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom_range(0, 1));
    lat = -1;
    busy_cycles = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        break;
      end
    end
    o_s = S; o_cout = Cout; o_ovf = ovf;
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [N-1:0] got_s, exp_s;
    logic         got_c, got_v, exp_c, exp_v;
    int           lat, bcyc, ndone, t1, t2;
    logic [N-1:0] s1, s2;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 32'h2143_6588, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_S", S, 0);
    chk("reset_Cout", Cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, got_s, got_c, got_v, lat, bcyc);
      $display("vec %0d: a=%h b=%h cin=%0d -> s=%h cout=%0d ovf=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, got_s, got_c, got_v, lat);
      chk($sformatf("vec%0d_S", i), got_s, vecs[i].s);
      chk($sformatf("vec%0d_Cout", i), got_c, vecs[i].cout);
      chk($sformatf("vec%0d_ovf", i), got_v, vecs[i].ovf);
      chk($sformatf("vec%0d_latency", i), lat, WORDS);
      chk($sformatf("vec%0d_busy_cycles", i), bcyc, WORDS);
      @(negedge clk);
      chk($sformatf("vec%0d_done_single", i), done, 0);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_S_held", i), S, vecs[i].s);
      chk($sformatf("vec%0d_Cout_held", i), Cout, vecs[i].cout);
    end

    // Reset in the middle of RUN
    @(negedge clk);
    A = 32'h1234_5678; B = 32'h1111_1111; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("mid-run reset: S=%h busy=%0d done=%0d", S, busy, done);
    chk("midrst_S", S, 0);
    chk("midrst_Cout", Cout, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // Start ignored during RUN
    @(negedge clk);
    A = 32'h0000_0080; B = 32'h0000_0020; Cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    A = 32'h0000_0020; B = 32'h0000_0022; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    s1 = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        s1 = S;
      end
    end
    $display("ignored start: S=%h done_pulses=%0d", s1, ndone);
    chk("ign_S", s1, 32'h0000_00A1);
    chk("ign_done_count", ndone, 1);

    // Back-to-back with start held high
    @(negedge clk);
    A = 32'h0000_005D; B = 32'h0000_002B; Cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    A = 32'h0000_0000; B = 32'h0000_000C; Cin = 1'b1;
    t1 = -1; t2 = -1; s1 = '0; s2 = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) begin
          t1 = i; s1 = S;
        end else begin
          t2 = i; s2 = S;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    $display("back-to-back: S1=%h S2=%h gap=%0d", s1, s2, t2 - t1);
    chk("b2b_S1", s1, 32'h0000_0089);
    chk("b2b_S2", s2, 32'h0000_000D);
    chk("b2b_first_latency", t1, WORDS);
    chk("b2b_gap", t2 - t1, WORDS + 1);
    repeat (WORDS + 3) @(negedge clk);
    chk("b2b_idle", busy, 0);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] ra, rb;
      logic         rc;
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (i % 4 == 0) rb = ~ra;
      ref_add(ra, rb, rc, exp_s, exp_c, exp_v);
      run_op(ra, rb, rc, got_s, got_c, got_v, lat, bcyc);
      $display("rand %0d: a=%h b=%h cin=%0d -> s=%h cout=%0d ovf=%0d", i, ra, rb, rc, got_s, got_c, got_v);
      chk($sformatf("rand%0d_S", i), got_s, exp_s);
      chk($sformatf("rand%0d_Cout", i), got_c, exp_c);
      chk($sformatf("rand%0d_ovf", i), got_v, exp_v);
      chk($sformatf("rand%0d_latency", i), lat, WORDS);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
